// File: rtl/bec_pkg.sv
// Shared constants and state type for the binary-Edwards scalar-key feeder.
package bec_pkg;

   localparam int KEY_W          = 163;
   localparam int WORD_W         = 32;
   localparam int NUM_WORDS      = 6;
   localparam int LAST_WORD_BITS = 3;
   localparam int CNT_W          = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SERVE = 2'd2,
      DONE  = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/bec_key_shifter.sv
// Key working register (MSB-first shift-out) with a bits-remaining down-counter.
module bec_key_shifter
   import bec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             clear,
   input  logic [KEY_W-1:0] load_val,
   output logic             msb,
   output logic [CNT_W-1:0] bits_left
);

   logic [KEY_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (load) begin
         sr_d  = load_val;
         cnt_d = CNT_W'(KEY_W);
      end else if (shift) begin
         sr_d = {sr_q[KEY_W-2:0], 1'b0};
         // saturate at zero so a stray shift can never wrap the count
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign msb       = sr_q[KEY_W-1];
   assign bits_left = cnt_q;

endmodule

// File: rtl/bec_key_feeder.sv
// Scalar-key feeder: staging buffer written in words, served one bit per next_key, MSB first.
//   state | meaning
//   IDLE  | waiting for writes or start
//   SCAN  | dropping leading zero bits (SKIP_LZ builds only)
//   SERVE | ki valid, one bit consumed per next_key
//   DONE  | all bits consumed, key_done held until start or write
module bec_key_feeder
   import bec_pkg::*;
#(
   parameter bit SKIP_LZ = 1'b0
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wr_en,
   input  logic [2:0]          wr_idx,
   input  logic [WORD_W-1:0]   wr_data,
   input  logic                start,
   input  logic                abort,
   input  logic                next_key,
   output logic                ki,
   output logic                key_rdy,
   output logic                key_last,
   output logic [CNT_W-1:0]    bits_left,
   output logic                busy,
   output logic                key_done,
   output logic                zero_key,
   output logic                err_wr
);

   feeder_state_t    state_q, state_d;
   logic [KEY_W-1:0] key_buf_q, key_buf_d;
   logic             key_done_q, key_done_d;
   logic             zero_key_q, zero_key_d;
   logic             err_wr_q, err_wr_d;

   logic sh_load, sh_shift, sh_clear, sh_msb;
   logic idle_or_done;

   bec_key_shifter u_shifter (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .load      (sh_load),
      .shift     (sh_shift),
      .clear     (sh_clear),
      .load_val  (key_buf_q),
      .msb       (sh_msb),
      .bits_left (bits_left)
   );

   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

   always_comb begin
      state_d    = state_q;
      key_buf_d  = key_buf_q;
      key_done_d = key_done_q;
      zero_key_d = zero_key_q;
      err_wr_d   = 1'b0;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      sh_clear   = 1'b0;

      if (abort) begin
         // abort wins over everything; a concurrent write is silently dropped
         state_d    = IDLE;
         sh_clear   = 1'b1;
         key_done_d = 1'b0;
         zero_key_d = 1'b0;
      end else begin
         if (wr_en) begin
            if (idle_or_done && !start && (wr_idx < 3'd6)) begin
               for (int w = 0; w < NUM_WORDS - 1; w++) begin
                  if (wr_idx == 3'(w)) begin
                     key_buf_d[w*WORD_W +: WORD_W] = wr_data;
                  end
               end
               if (wr_idx == 3'd5) begin
                  key_buf_d[KEY_W-1 -: LAST_WORD_BITS] = wr_data[LAST_WORD_BITS-1:0];
               end
               if (state_q == DONE) begin
                  state_d    = IDLE;
                  key_done_d = 1'b0;
                  zero_key_d = 1'b0;
               end
            end else begin
               err_wr_d = 1'b1;
            end
         end

         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  sh_load    = 1'b1;
                  key_done_d = 1'b0;
                  zero_key_d = 1'b0;
                  state_d    = SKIP_LZ ? SCAN : SERVE;
               end
            end
            SCAN: begin
               if (sh_msb) begin
                  state_d = SERVE;
               end else if (bits_left > CNT_W'(1)) begin
                  sh_shift = 1'b1;
               end else begin
                  state_d    = DONE;
                  sh_clear   = 1'b1;
                  key_done_d = 1'b1;
                  zero_key_d = 1'b1;
               end
            end
            SERVE: begin
               if (next_key) begin
                  sh_shift = 1'b1;
                  if (bits_left == CNT_W'(1)) begin
                     state_d    = DONE;
                     key_done_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         key_buf_q  <= '0;
         key_done_q <= 1'b0;
         zero_key_q <= 1'b0;
         err_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_buf_q  <= key_buf_d;
         key_done_q <= key_done_d;
         zero_key_q <= zero_key_d;
         err_wr_q   <= err_wr_d;
      end
   end

   assign key_rdy  = (state_q == SERVE);
   assign ki       = key_rdy & sh_msb;
   assign key_last = key_rdy && (bits_left == CNT_W'(1));
   assign busy     = (state_q == SCAN) || (state_q == SERVE);
   assign key_done = key_done_q;
   assign zero_key = zero_key_q;
   assign err_wr   = err_wr_q;

endmodule

// File: tb/tb_bec_key_feeder.sv
// Directed bench for bec_key_feeder: instance a without, instance b with leading-zero skip.
module tb_bec_key_feeder;

   logic        clk = 1'b0;
   logic        wb_rst_i, wr_en, start, abort, next_key;
   logic [2:0]  wr_idx;
   logic [31:0] wr_data;

   logic       ki_a, key_rdy_a, key_last_a, busy_a, key_done_a, zero_key_a, err_wr_a;
   logic [7:0] bits_left_a;
   logic       ki_b, key_rdy_b, key_last_b, busy_b, key_done_b, zero_key_b, err_wr_b;
   logic [7:0] bits_left_b;

   int checks = 0;
   int errors = 0;

   logic [162:0] key1;
   logic [162:0] key5;

   always #5 clk = ~clk;

   bec_key_feeder #(.SKIP_LZ(1'b0)) u_dut_a (
      .wb_clk_i (clk),        .wb_rst_i (wb_rst_i),
      .wr_en    (wr_en),      .wr_idx   (wr_idx),     .wr_data  (wr_data),
      .start    (start),      .abort    (abort),      .next_key (next_key),
      .ki       (ki_a),       .key_rdy  (key_rdy_a),  .key_last (key_last_a),
      .bits_left(bits_left_a),.busy     (busy_a),     .key_done (key_done_a),
      .zero_key (zero_key_a), .err_wr   (err_wr_a)
   );

   bec_key_feeder #(.SKIP_LZ(1'b1)) u_dut_b (
      .wb_clk_i (clk),        .wb_rst_i (wb_rst_i),
      .wr_en    (wr_en),      .wr_idx   (wr_idx),     .wr_data  (wr_data),
      .start    (start),      .abort    (abort),      .next_key (next_key),
      .ki       (ki_b),       .key_rdy  (key_rdy_b),  .key_last (key_last_b),
      .bits_left(bits_left_b),.busy     (busy_b),     .key_done (key_done_b),
      .zero_key (zero_key_b), .err_wr   (err_wr_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [2:0] idx, input logic [31:0] d);
      wr_en = 1'b1; wr_idx = idx; wr_data = d;
      step();
      wr_en = 1'b0; wr_idx = 3'd0; wr_data = 32'd0;
   endtask

   task automatic write_key(input logic [162:0] k);
      logic [191:0] kx;
      kx = {29'd0, k};
      for (int w = 0; w < 6; w++) write_word(3'(w), kx[w*32 +: 32]);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1; step(); abort = 1'b0;
   endtask

   task automatic pulse_next();
      next_key = 1'b1; step(); next_key = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 32'd0;
      start = 1'b0; abort = 1'b0; next_key = 1'b0;
      step(); step();
      wb_rst_i = 1'b0;
      checks++;
      if ({ki_a, key_rdy_a, key_last_a, bits_left_a, busy_a, key_done_a, zero_key_a, err_wr_a} !== 15'd0) begin
         errors++;
         $display("FAIL reset_a: outputs=%h required 0", {ki_a, key_rdy_a, key_last_a, bits_left_a, busy_a, key_done_a, zero_key_a, err_wr_a});
      end
      checks++;
      if ({ki_b, key_rdy_b, key_last_b, bits_left_b, busy_b, key_done_b, zero_key_b, err_wr_b} !== 15'd0) begin
         errors++;
         $display("FAIL reset_b: outputs=%h required 0", {ki_b, key_rdy_b, key_last_b, bits_left_b, busy_b, key_done_b, zero_key_b, err_wr_b});
      end
   endtask

   task automatic test_serve_full();
      int bl;
      pulse_abort();
      write_key(key1);
      pulse_start();
      step(); step();
      for (int i = 0; i < 163; i++) begin
         bl = 163 - i;
         checks++;
         if (ki_a !== key1[bl-1] || bits_left_a !== 8'(bl) || key_last_a !== (bl == 1) || key_rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL serve_full bit %0d: ki=%b left=%0d last=%b rdy=%b required ki=%b left=%0d last=%b rdy=1",
                     bl - 1, ki_a, bits_left_a, key_last_a, key_rdy_a, key1[bl-1], bl, (bl == 1));
         end
         pulse_next();
      end
      checks++;
      if (key_done_a !== 1'b1 || bits_left_a !== 8'd0 || ki_a !== 1'b0 || key_rdy_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL serve_full_done: done=%b left=%0d ki=%b rdy=%b busy=%b required 1 0 0 0 0",
                  key_done_a, bits_left_a, ki_a, key_rdy_a, busy_a);
      end
   endtask

   task automatic test_skip_lz();
      int scan_bad;
      logic [2:0] exp_ki;
      pulse_abort();
      write_key(key5);
      pulse_start();
      scan_bad = 0;
      for (int k = 0; k < 160; k++) begin
         if (key_rdy_b !== 1'b0 || busy_b !== 1'b1) scan_bad++;
         step();
      end
      checks++;
      if (scan_bad != 0 || key_rdy_b !== 1'b0 || busy_b !== 1'b1 || bits_left_b !== 8'd3) begin
         errors++;
         $display("FAIL skip_lz_scan: bad_cycles=%0d rdy=%b busy=%b left=%0d required 0 0 1 3",
                  scan_bad, key_rdy_b, busy_b, bits_left_b);
      end
      step();
      exp_ki = 3'b101;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (key_rdy_b !== 1'b1 || ki_b !== exp_ki[2-i] || bits_left_b !== 8'(3 - i) || key_last_b !== (i == 2)) begin
            errors++;
            $display("FAIL skip_lz_serve %0d: rdy=%b ki=%b left=%0d last=%b required 1 %b %0d %b",
                     i, key_rdy_b, ki_b, bits_left_b, key_last_b, exp_ki[2-i], 3 - i, (i == 2));
         end
         pulse_next();
      end
      checks++;
      if (key_done_b !== 1'b1 || zero_key_b !== 1'b0 || bits_left_b !== 8'd0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL skip_lz_done: done=%b zero=%b left=%0d busy=%b required 1 0 0 0",
                  key_done_b, zero_key_b, bits_left_b, busy_b);
      end
   endtask

   task automatic test_zero_key();
      int bad;
      pulse_abort();
      write_key(163'd0);
      pulse_start();
      bad = 0;
      for (int k = 0; k < 162; k++) begin
         step();
         if (key_rdy_b !== 1'b0 || key_done_b !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || bits_left_b !== 8'd1 || busy_b !== 1'b1) begin
         errors++;
         $display("FAIL zero_key_scan: bad_cycles=%0d left=%0d busy=%b required 0 1 1", bad, bits_left_b, busy_b);
      end
      step();
      checks++;
      if (key_done_b !== 1'b1 || zero_key_b !== 1'b1 || bits_left_b !== 8'd0 || busy_b !== 1'b0 || key_rdy_b !== 1'b0) begin
         errors++;
         $display("FAIL zero_key_done: done=%b zero=%b left=%0d busy=%b rdy=%b required 1 1 0 0 0",
                  key_done_b, zero_key_b, bits_left_b, busy_b, key_rdy_b);
      end
      write_word(3'd0, 32'd0);
      checks++;
      if (key_done_b !== 1'b0 || zero_key_b !== 1'b0 || err_wr_b !== 1'b0) begin
         errors++;
         $display("FAIL zero_key_write_clear: done=%b zero=%b err=%b required 0 0 0", key_done_b, zero_key_b, err_wr_b);
      end
   endtask

   task automatic test_bad_write();
      int bl;
      pulse_abort();
      write_key(key1);
      write_word(3'd6, 32'hFFFF_FFFF);
      checks++;
      if (err_wr_a !== 1'b1) begin
         errors++;
         $display("FAIL bad_write_idx6: err_wr=%b required 1", err_wr_a);
      end
      step();
      checks++;
      if (err_wr_a !== 1'b0) begin
         errors++;
         $display("FAIL bad_write_pulse: err_wr=%b required 0", err_wr_a);
      end
      wr_en = 1'b1; wr_idx = 3'd0; wr_data = 32'hFFFF_FFFF; start = 1'b1;
      step();
      wr_en = 1'b0; start = 1'b0;
      checks++;
      if (err_wr_a !== 1'b1 || key_rdy_a !== 1'b1 || bits_left_a !== 8'd163 || ki_a !== 1'b1) begin
         errors++;
         $display("FAIL bad_write_with_start: err=%b rdy=%b left=%0d ki=%b required 1 1 163 1",
                  err_wr_a, key_rdy_a, bits_left_a, ki_a);
      end
      for (int i = 0; i < 5; i++) pulse_next();
      write_word(3'd0, 32'hFFFF_FFFF);
      checks++;
      if (err_wr_a !== 1'b1 || bits_left_a !== 8'd158 || ki_a !== 1'b0 || key_rdy_a !== 1'b1) begin
         errors++;
         $display("FAIL bad_write_serve: err=%b left=%0d ki=%b rdy=%b required 1 158 0 1",
                  err_wr_a, bits_left_a, ki_a, key_rdy_a);
      end
      for (int i = 0; i < 158; i++) begin
         bl = 158 - i;
         checks++;
         if (ki_a !== key1[bl-1] || bits_left_a !== 8'(bl)) begin
            errors++;
            $display("FAIL bad_write_rest bit %0d: ki=%b left=%0d required ki=%b left=%0d",
                     bl - 1, ki_a, bits_left_a, key1[bl-1], bl);
         end
         pulse_next();
      end
      checks++;
      if (key_done_a !== 1'b1) begin
         errors++;
         $display("FAIL bad_write_done: key_done=%b required 1", key_done_a);
      end
   endtask

   task automatic test_abort_restart();
      int bl;
      pulse_start();
      for (int i = 0; i < 50; i++) pulse_next();
      checks++;
      if (bits_left_a !== 8'd113 || key_rdy_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: left=%0d rdy=%b required 113 1", bits_left_a, key_rdy_a);
      end
      pulse_abort();
      checks++;
      if (busy_a !== 1'b0 || key_rdy_a !== 1'b0 || bits_left_a !== 8'd0 || ki_a !== 1'b0 || key_done_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b rdy=%b left=%0d ki=%b done=%b required 0 0 0 0 0",
                  busy_a, key_rdy_a, bits_left_a, ki_a, key_done_a);
      end
      pulse_start();
      for (int i = 0; i < 163; i++) begin
         bl = 163 - i;
         checks++;
         if (ki_a !== key1[bl-1] || bits_left_a !== 8'(bl)) begin
            errors++;
            $display("FAIL abort_restart bit %0d: ki=%b left=%0d required ki=%b left=%0d",
                     bl - 1, ki_a, bits_left_a, key1[bl-1], bl);
         end
         pulse_next();
      end
      checks++;
      if (key_done_a !== 1'b1 || bits_left_a !== 8'd0) begin
         errors++;
         $display("FAIL abort_restart_done: done=%b left=%0d required 1 0", key_done_a, bits_left_a);
      end
   endtask

   task automatic test_abort_priority();
      int bl;
      pulse_start();
      abort = 1'b1; start = 1'b1; next_key = 1'b1;
      wr_en = 1'b1; wr_idx = 3'd0; wr_data = 32'hFFFF_FFFF;
      step();
      abort = 1'b0; start = 1'b0; next_key = 1'b0; wr_en = 1'b0; wr_data = 32'd0;
      checks++;
      if (busy_a !== 1'b0 || key_rdy_a !== 1'b0 || bits_left_a !== 8'd0 || err_wr_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: busy=%b rdy=%b left=%0d err=%b required 0 0 0 0",
                  busy_a, key_rdy_a, bits_left_a, err_wr_a);
      end
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || err_wr_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_beats_start_idle: busy=%b err=%b required 0 0", busy_a, err_wr_a);
      end
      pulse_next();
      checks++;
      if (bits_left_a !== 8'd0 || key_done_a !== 1'b0) begin
         errors++;
         $display("FAIL next_key_idle: left=%0d done=%b required 0 0", bits_left_a, key_done_a);
      end
      pulse_start();
      for (int i = 0; i < 163; i++) begin
         bl = 163 - i;
         checks++;
         if (ki_a !== key1[bl-1] || bits_left_a !== 8'(bl)) begin
            errors++;
            $display("FAIL abort_priority_buf bit %0d: ki=%b left=%0d required ki=%b left=%0d",
                     bl - 1, ki_a, bits_left_a, key1[bl-1], bl);
         end
         pulse_next();
      end
   endtask

   task automatic test_reset_mid();
      pulse_start();
      pulse_next(); pulse_next();
      wb_rst_i = 1'b1; step(); wb_rst_i = 1'b0;
      checks++;
      if ({ki_a, key_rdy_a, key_last_a, bits_left_a, busy_a, key_done_a, zero_key_a, err_wr_a} !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid: outputs=%h required 0", {ki_a, key_rdy_a, key_last_a, bits_left_a, busy_a, key_done_a, zero_key_a, err_wr_a});
      end
      pulse_start();
      checks++;
      if (key_rdy_a !== 1'b1 || bits_left_a !== 8'd163 || ki_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_buf_cleared: rdy=%b left=%0d ki=%b required 1 163 0", key_rdy_a, bits_left_a, ki_a);
      end
   endtask

   initial begin
      key1 = {1'b1, 161'd0, 1'b1};
      key5 = 163'h5;
      test_reset();
      test_serve_full();
      test_skip_lz();
      test_zero_key();
      test_bad_write();
      test_abort_restart();
      test_abort_priority();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bec_key_feeder.md
Name: bec_key_feeder

Overview:
Upstream scalar-key source for the 163-bit binary-Edwards scalar-multiplication core. Software writes the key as 32-bit words into a staging buffer. On start, the block copies the buffer into a working shift register and serves one key bit per next_key request on ki, MSB first. Reports progress, last bit and completion to the controller.

Parameters:
KEY_W, 163, scalar key width in bits.
WORD_W, 32, write-port word width.
NUM_WORDS, 6, staging words; ceil(KEY_W/WORD_W).
SKIP_LZ, 0, 1 = drop leading zero bits before serving (timing-leaky, test use only).

Ports:
wb_clk_i  in  1  clock.
wb_rst_i  in  1  synchronous reset, active-high.
wr_en  in  1  write strobe for the staging buffer.
wr_idx  in  3  word index; 0 = bits[31:0] … 5 = bits[162:160].
wr_data  in  32  write word.
start  in  1  single-cycle pulse: begin serving the staged key.
abort  in  1  single-cycle pulse: return to IDLE.
next_key  in  1  single-cycle pulse from the core: consume current ki.
ki  out  1  current key bit.
key_rdy  out  1  ki valid (SERVE state).
key_last  out  1  ki is the final bit.
bits_left  out  8  bits not yet consumed.
busy  out  1  SCAN or SERVE.
key_done  out  1  all bits consumed; level signal.
zero_key  out  1  SKIP_LZ scan found an all-zero key; level signal.
err_wr  out  1  one-cycle pulse: rejected write.

Behaviour:
- Reset (sync, wb_rst_i=1 at the clock edge):
  - staging buffer = 0, shift register = 0, bits_left = 0, state = IDLE.
  - All outputs 0.
- States: IDLE, SCAN, SERVE, DONE.
- Writes:
  - Accepted only in IDLE or DONE, and only when start is not asserted in the same cycle.
  - wr_idx 5 stores wr_data[2:0] only; upper bits are discarded.
  - A write in DONE clears key_done and zero_key and moves to IDLE.
  - wr_idx 6 or 7, a write in SCAN/SERVE, or a write in the same cycle as start: write is dropped and err_wr pulses one cycle later.
- start (in IDLE or DONE):
  - Next cycle: shift register = buffer, bits_left = 163, key_done and zero_key cleared.
  - State -> SCAN if SKIP_LZ=1, else SERVE.
  - start in SCAN or SERVE is ignored.
- SCAN (one bit per cycle):
  - If MSB=1 -> SERVE.
  - Else if bits_left > 1: shift left, bits_left-1.
  - Else (bits_left=1, MSB=0) -> DONE with zero_key=1, key_done=1, bits_left=0.
- SERVE:
  - ki = shift register MSB; key_rdy=1; key_last = (bits_left==1).
  - ki is stable until next_key.
  - On next_key: shift left by 1, bits_left-1.
  - If bits_left was 1 -> DONE with key_done=1, bits_left=0, ki=0.
  - No consume latency: the new ki is visible the cycle after next_key.
  - next_key is ignored outside SERVE.
- DONE: key_done=1 and the shift register is held at 0 until start or write.
- abort:
  - Any state -> IDLE next cycle.
  - Clears shift register, bits_left, key_done and zero_key.
  - The staging buffer is preserved.
  - abort beats start, next_key and writes in the same cycle; a write with abort is dropped, with no err_wr.
- Reset mid-operation behaves the same as abort, but also clears the buffer.
- busy = state in {SCAN, SERVE}.
- bits_left never wraps below 0.

Decomposition:
- Shared package bec_pkg holds:
  - KEY_W = 163, NUM_WORDS = 6, LAST_WORD_BITS = 3;
  - state enum feeder_state_t {IDLE, SCAN, SERVE, DONE};
  - bits_left width constant, 8.
- One sub-module: bec_key_shifter, the KEY_W shift register plus bits_left down-counter with load/shift/clear controls.
- The FSM and staging buffer live in bec_key_feeder.

Test Plan:
1. Write key = 163'h4_0000…0001 (words 0..5, word5 = 32'h4), start, then 163 next_key pulses. Required:
   - ki = 1 on the first and last bits;
   - key_last=1 only before the final pulse;
   - key_done=1 after it;
   - bits_left counts 163 -> 0.
2. SKIP_LZ=1, key = 163'h5, start. Required:
   - SCAN lasts 160 cycles;
   - SERVE starts with bits_left = 3;
   - ki sequence 1, 0, 1; then key_done.
3. SKIP_LZ=1, all-zero key, start. Required: DONE after 163 cycles with zero_key=1, key_done=1, key_rdy never asserted.
4. Write to wr_idx=6, and write during SERVE. Required:
   - err_wr pulses once per write;
   - buffer and ki unchanged;
   - the served sequence matches the original key.
5. abort after 50 next_key pulses, then start. Required:
   - IDLE with bits_left = 0 the cycle after abort;
   - the restart serves the full key again from bit 162.
6. start, next_key and a wr_idx=0 write together with abort in one cycle. Required: IDLE, no err_wr, buffer word 0 unchanged.
